// File: rtl/cop_pkg.sv
// Shared definitions for the custom-instruction co-processor port.
// Request FSM encoding, CUSTOM_0..3 major opcodes and an opcode classifier.
// No logic of its own; nothing to stall.
package cop_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } cop_state_e;

    localparam logic [6:0] OPC_CUSTOM_0 = 7'b0001011;
    localparam logic [6:0] OPC_CUSTOM_1 = 7'b0101011;
    localparam logic [6:0] OPC_CUSTOM_2 = 7'b1011011;
    localparam logic [6:0] OPC_CUSTOM_3 = 7'b1111011;

    function automatic logic is_custom(input logic [31:0] insn);
        return (insn[6:0] == OPC_CUSTOM_0) || (insn[6:0] == OPC_CUSTOM_1) ||
               (insn[6:0] == OPC_CUSTOM_2) || (insn[6:0] == OPC_CUSTOM_3);
    endfunction

endpackage

// File: rtl/cop_res_buf.sv
// One-entry writeback buffer between the co-processor result and the register file.
// Load-to-wb_valid latency 1 cycle; the entry stays put until wb_ready.
// o_rdywr is low only while full and not draining; a same-cycle drain frees the slot.
module cop_res_buf #(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_load,
    input  logic [4:0]      i_load_rd,
    input  logic [XLEN-1:0] i_load_data,
    input  logic            i_wb_ready,
    output logic            o_rdywr,
    output logic            o_wb_valid,
    output logic [4:0]      o_wb_addr,
    output logic [XLEN-1:0] o_wb_data
);

    logic            r_full;
    logic [4:0]      r_addr;
    logic [XLEN-1:0] r_data;
    logic            w_keep;

    // x0 writes are architecturally void, so they never occupy the slot
    assign w_keep     = i_load && (i_load_rd != 5'd0);
    assign o_rdywr    = !r_full || i_wb_ready;
    assign o_wb_valid = r_full;
    assign o_wb_addr  = r_addr;
    assign o_wb_data  = r_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (w_keep) begin
            r_full <= 1'b1;
            r_addr <= i_load_rd;
            r_data <= i_load_data;
        end else if (i_wb_ready) begin
            r_full <= 1'b0;
        end
    end

endmodule

// File: rtl/cop_issue.sv
// Core-side initiator: issues one CUSTOM_x instruction to the co-processor, buffers the result.
// Accept at N -> cop_valid at N+1 -> wb_valid at N+2 with a same-cycle responder.
// req_ready only in IDLE; ISSUE holds while the result buffer is full or the co-processor waits.
module cop_issue
    import cop_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 255
) (
    input  logic            cop_clk,
    input  logic            cop_rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_insn,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic [4:0]      req_rd,
    output logic            cop_valid,
    output logic [31:0]     cop_insn,
    output logic [XLEN-1:0] cop_rs1,
    output logic [XLEN-1:0] cop_rs2,
    output logic            cop_rdywr,
    input  logic            cop_wr,
    input  logic            cop_wait,
    input  logic            cop_ready,
    input  logic [XLEN-1:0] cop_rd,
    output logic            wb_valid,
    output logic [4:0]      wb_addr,
    output logic [XLEN-1:0] wb_data,
    input  logic            wb_ready,
    output logic            ill_insn
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    cop_state_e      r_state;
    cop_state_e      w_next_state;
    logic [31:0]     r_insn;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [4:0]      r_rd;
    logic [7:0]      r_wait_cnt;
    logic            w_accept;
    logic            w_load;
    logic            w_cnt_inc;
    logic            w_ill;
    logic            w_rdywr;

    always_ff @(posedge cop_clk or negedge cop_rst) begin
        if (!cop_rst) begin
            r_state    <= ST_IDLE;
            r_insn     <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_insn     <= req_insn;
                r_rs1      <= req_rs1;
                r_rs2      <= req_rs2;
                r_rd       <= req_rd;
                r_wait_cnt <= '0;
            end else if (w_cnt_inc && (r_wait_cnt != 8'hFF)) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_load       = 1'b0;
        w_cnt_inc    = 1'b0;
        w_ill        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // a stalled co-processor's wr/wait lines carry no decision yet
                if (cop_ready) begin
                    if (cop_wr) begin
                        if (w_rdywr) begin
                            w_load       = 1'b1;
                            w_next_state = ST_IDLE;
                        end
                    end else if (cop_wait) begin
                        w_cnt_inc = 1'b1;
                        if (r_wait_cnt >= TO_LAST) begin
                            w_ill        = 1'b1;
                            w_next_state = ST_IDLE;
                        end
                    end else begin
                        w_ill        = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign req_ready = (r_state == ST_IDLE);
    assign cop_valid = (r_state == ST_ISSUE);
    assign cop_insn  = r_insn;
    assign cop_rs1   = r_rs1;
    assign cop_rs2   = r_rs2;
    assign cop_rdywr = w_rdywr;
    assign ill_insn  = w_ill;

    cop_res_buf #(.XLEN(XLEN)) u_res_buf (
        .i_clk       (cop_clk),
        .i_rst_n     (cop_rst),
        .i_load      (w_load),
        .i_load_rd   (r_rd),
        .i_load_data (cop_rd),
        .i_wb_ready  (wb_ready),
        .o_rdywr     (w_rdywr),
        .o_wb_valid  (wb_valid),
        .o_wb_addr   (wb_addr),
        .o_wb_data   (wb_data)
    );

endmodule

// File: tb/tb_cop_issue.sv
// Directed bench for cop_issue with a same-cycle co-processor stub (TIMEOUT = 4).
module tb_cop_issue;

    localparam int XLEN = 64;

    logic            cop_clk = 1'b0;
    logic            cop_rst;
    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_insn;
    logic [XLEN-1:0] req_rs1, req_rs2;
    logic [4:0]      req_rd;
    logic            cop_valid;
    logic [31:0]     cop_insn;
    logic [XLEN-1:0] cop_rs1, cop_rs2;
    logic            cop_rdywr;
    logic            cop_wr, cop_wait, cop_ready;
    logic [XLEN-1:0] cop_rd;
    logic            wb_valid;
    logic [4:0]      wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            wb_ready;
    logic            ill_insn;

    int checks   = 0;
    int failures = 0;

    // stub: 0 = never claims, 1 = same-cycle result, 2 = waits forever
    int              stub_mode;
    logic [XLEN-1:0] stub_rd;

    assign cop_wr   = cop_valid && (stub_mode == 1);
    assign cop_wait = cop_valid && (stub_mode == 2);
    assign cop_rd   = stub_rd;

    always #5 cop_clk = ~cop_clk;

    cop_issue #(.XLEN(XLEN), .TIMEOUT(4)) dut (
        .cop_clk(cop_clk), .cop_rst(cop_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_insn(req_insn),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .cop_valid(cop_valid), .cop_insn(cop_insn), .cop_rs1(cop_rs1), .cop_rs2(cop_rs2),
        .cop_rdywr(cop_rdywr), .cop_wr(cop_wr), .cop_wait(cop_wait), .cop_ready(cop_ready),
        .cop_rd(cop_rd), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_ready(wb_ready), .ill_insn(ill_insn)
    );

    task automatic tick();
        @(posedge cop_clk);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] insn, input logic [XLEN-1:0] rs1,
                             input logic [XLEN-1:0] rs2, input logic [4:0] rd);
        req_valid = 1'b1;
        req_insn  = insn;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_rd    = rd;
    endtask

    task automatic test_reset();
        cop_rst = 1'b0; req_valid = 1'b0; req_insn = '0; req_rs1 = '0; req_rs2 = '0;
        req_rd = '0; cop_ready = 1'b1; wb_ready = 1'b0; stub_mode = 0; stub_rd = '0;
        tick(); tick();
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
        checks++; if (cop_valid !== 1'b0) begin failures++; $display("FAIL rst_cop_valid got=%b exp=0", cop_valid); end
        checks++; if (cop_insn !== 32'h0 || cop_rs1 !== '0 || cop_rs2 !== '0) begin failures++; $display("FAIL rst_cop_payload got=%h/%h/%h exp=0", cop_insn, cop_rs1, cop_rs2); end
        checks++; if (cop_rdywr !== 1'b1) begin failures++; $display("FAIL rst_cop_rdywr got=%b exp=1", cop_rdywr); end
        checks++; if (wb_valid !== 1'b0 || wb_addr !== 5'd0 || wb_data !== '0) begin failures++; $display("FAIL rst_wb got=%b/%0d/%h exp=0/0/0", wb_valid, wb_addr, wb_data); end
        checks++; if (ill_insn !== 1'b0) begin failures++; $display("FAIL rst_ill got=%b exp=0", ill_insn); end
        tick();
        cop_rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        stub_mode = 1; stub_rd = 64'h3;
        drive_req(32'h8000_002B, 64'h1, 64'h2, 5'd5);
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL basic_accept got=%b exp=1", req_ready); end
        tick(); req_valid = 1'b0; #1;                                     // N+1
        checks++; if (cop_valid !== 1'b1 || cop_insn !== 32'h8000_002B || cop_rs1 !== 64'h1 || cop_rs2 !== 64'h2) begin
            failures++; $display("FAIL basic_issue got=%b/%h/%h/%h exp=1/8000002b/1/2", cop_valid, cop_insn, cop_rs1, cop_rs2); end
        checks++; if (ill_insn !== 1'b0 || wb_valid !== 1'b0) begin failures++; $display("FAIL basic_n1 ill/wb got=%b/%b exp=0/0", ill_insn, wb_valid); end
        tick(); #1;                                                       // N+2
        checks++; if (wb_valid !== 1'b1 || wb_addr !== 5'd5 || wb_data !== 64'h3) begin
            failures++; $display("FAIL basic_wb got=%b/%0d/%h exp=1/5/3", wb_valid, wb_addr, wb_data); end
        checks++; if (cop_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL basic_idle got=%b/%b exp=0/1", cop_valid, req_ready); end
        wb_ready = 1'b1;
        tick(); #1;
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%b exp=0", wb_valid); end
        wb_ready = 1'b0;
    endtask

    task automatic test_unclaimed();
        stub_mode = 0;
        drive_req(32'h0000_000B, 64'h7, 64'h8, 5'd7);
        tick(); req_valid = 1'b0; #1;                                     // N+1
        checks++; if (ill_insn !== 1'b1 || cop_valid !== 1'b1 || req_ready !== 1'b0) begin
            failures++; $display("FAIL uncl_n1 ill/valid/rdy got=%b/%b/%b exp=1/1/0", ill_insn, cop_valid, req_ready); end
        tick(); #1;                                                       // N+2
        checks++; if (ill_insn !== 1'b0 || req_ready !== 1'b1 || wb_valid !== 1'b0) begin
            failures++; $display("FAIL uncl_n2 ill/rdy/wb got=%b/%b/%b exp=0/1/0", ill_insn, req_ready, wb_valid); end
    endtask

    task automatic test_back_to_back();
        stub_mode = 1; stub_rd = 64'hA; wb_ready = 1'b0;
        drive_req(32'h8000_002B, 64'h11, 64'h12, 5'd5);
        tick();                                                           // N+1: first in ISSUE
        drive_req(32'h0000_005B, 64'h21, 64'h22, 5'd6);
        tick(); stub_rd = 64'hB; #1;                                      // N+2: second accepted
        checks++; if (req_ready !== 1'b1 || wb_valid !== 1'b1 || wb_addr !== 5'd5 || wb_data !== 64'hA) begin
            failures++; $display("FAIL b2b_first rdy/wb got=%b/%b/%0d/%h exp=1/1/5/a", req_ready, wb_valid, wb_addr, wb_data); end
        tick(); req_valid = 1'b0;                                         // N+3
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (cop_valid !== 1'b1 || cop_rdywr !== 1'b0 || cop_rs1 !== 64'h21 || cop_insn !== 32'h0000_005B || wb_addr !== 5'd5) begin
                failures++; $display("FAIL b2b_hold cyc=%0d valid/rdywr/rs1/addr got=%b/%b/%h/%0d exp=1/0/21/5", i, cop_valid, cop_rdywr, cop_rs1, wb_addr); end
            if (i < 2) tick();
        end
        wb_ready = 1'b1; #1;                                              // N+5: drain frees slot
        checks++; if (cop_rdywr !== 1'b1) begin failures++; $display("FAIL b2b_drain_rdywr got=%b exp=1", cop_rdywr); end
        tick(); #1;                                                       // N+6
        checks++; if (wb_valid !== 1'b1 || wb_addr !== 5'd6 || wb_data !== 64'hB || cop_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_second wb/addr/data/valid got=%b/%0d/%h/%b exp=1/6/b/0", wb_valid, wb_addr, wb_data, cop_valid); end
        tick(); #1;
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b exp=0", wb_valid); end
        wb_ready = 1'b0;
    endtask

    task automatic test_timeout();
        stub_mode = 2;
        drive_req(32'h0000_007B, 64'h5, 64'h6, 5'd3);
        tick(); req_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++; if (ill_insn !== (i == 4) || cop_valid !== 1'b1) begin
                failures++; $display("FAIL timeout_wait%0d ill/valid got=%b/%b exp=%b/1", i, ill_insn, cop_valid, (i == 4)); end
            tick();
        end
        #1;
        checks++; if (req_ready !== 1'b1 || cop_valid !== 1'b0 || ill_insn !== 1'b0 || wb_valid !== 1'b0) begin
            failures++; $display("FAIL timeout_after rdy/valid/ill/wb got=%b/%b/%b/%b exp=1/0/0/0", req_ready, cop_valid, ill_insn, wb_valid); end
        stub_mode = 0;
    endtask

    task automatic test_rd_zero();
        stub_mode = 1; stub_rd = 64'h55;
        drive_req(32'h8000_002B, 64'h1, 64'h1, 5'd0);
        tick(); req_valid = 1'b0; #1;
        checks++; if (ill_insn !== 1'b0) begin failures++; $display("FAIL rd0_ill got=%b exp=0", ill_insn); end
        tick();
        stub_rd = 64'h99;
        drive_req(32'h8000_002B, 64'h3, 64'h4, 5'd9); #1;
        checks++; if (wb_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL rd0_nowb wb/rdy got=%b/%b exp=0/1", wb_valid, req_ready); end
        tick(); req_valid = 1'b0; #1;
        checks++; if (cop_valid !== 1'b1 || cop_rs1 !== 64'h3) begin failures++; $display("FAIL rd0_next_issue got=%b/%h exp=1/3", cop_valid, cop_rs1); end
        tick(); #1;
        checks++; if (wb_valid !== 1'b1 || wb_addr !== 5'd9 || wb_data !== 64'h99) begin
            failures++; $display("FAIL rd0_next_wb got=%b/%0d/%h exp=1/9/99", wb_valid, wb_addr, wb_data); end
        wb_ready = 1'b1; tick(); wb_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        stub_mode = 1; stub_rd = 64'h44; wb_ready = 1'b0;
        drive_req(32'h8000_002B, 64'h1, 64'h2, 5'd4);
        tick();
        drive_req(32'h8000_002B, 64'h8, 64'h9, 5'd8);
        tick(); tick(); req_valid = 1'b0; #1;                             // second blocked in ISSUE, buffer full
        checks++; if (cop_valid !== 1'b1 || wb_valid !== 1'b1) begin failures++; $display("FAIL rstmid_setup got=%b/%b exp=1/1", cop_valid, wb_valid); end
        #2 cop_rst = 1'b0; #1;                                            // mid-cycle, no clock edge
        checks++; if (cop_valid !== 1'b0 || wb_valid !== 1'b0) begin failures++; $display("FAIL rstmid_async got=%b/%b exp=0/0", cop_valid, wb_valid); end
        stub_mode = 0;
        tick(); tick();
        #2 cop_rst = 1'b1;
        tick(); #1;
        checks++; if (req_ready !== 1'b1 || cop_valid !== 1'b0 || cop_insn !== 32'h0 || cop_rs1 !== '0 || cop_rs2 !== '0 || cop_rdywr !== 1'b1) begin
            failures++; $display("FAIL rstmid_req_side got=%b/%b/%h/%h/%h/%b exp=1/0/0/0/0/1", req_ready, cop_valid, cop_insn, cop_rs1, cop_rs2, cop_rdywr); end
        checks++; if (wb_valid !== 1'b0 || wb_addr !== 5'd0 || wb_data !== '0 || ill_insn !== 1'b0) begin
            failures++; $display("FAIL rstmid_wb_side got=%b/%0d/%h/%b exp=0/0/0/0", wb_valid, wb_addr, wb_data, ill_insn); end
        wb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rstmid_stale cyc=%0d got=%b exp=0", i, wb_valid); end
        end
        wb_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_unclaimed();
        test_back_to_back();
        test_timeout();
        test_rd_zero();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
